// File: rtl/dnn_io_pkg.sv
// Shared definitions for the DNN board I/O controller: register map,
// bus widths and the seven-segment glyph table.
package dnn_io_pkg;

    localparam int AVS_ADDR_W = 3;
    localparam int AVS_DATA_W = 32;

    // Avalon word addresses; 6 and 7 are left unmapped and read as zero.
    typedef enum logic [AVS_ADDR_W-1:0] {
        REG_SW       = 3'd0,
        REG_LED      = 3'd1,
        REG_HEXVAL   = 3'd2,
        REG_HEXBLANK = 3'd3,
        REG_EDGE     = 3'd4,
        REG_IRQMASK  = 3'd5
    } reg_addr_e;

    // Active-low segments in gfedcba order; a blanked digit drives all ones.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n is the glyph for hex digit n (index 15 is the leftmost element).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/dnn_io_ctrl_if.sv
// Avalon-MM slave bus plus the interrupt line of the I/O controller.
interface dnn_io_ctrl_if;
    import dnn_io_pkg::*;

    logic [AVS_ADDR_W-1:0] avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [AVS_DATA_W-1:0] avs_writedata;
    logic [AVS_DATA_W-1:0] avs_readdata;
    logic                  irq;

    // Host / CPU side.
    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, irq
    );

    // Peripheral side.
    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, irq
    );

endinterface

// File: rtl/dnn_io_ctrl_seg7_decode.sv
// Combinational hex-digit to seven-segment decode with blanking.
module seg7_decode
    import dnn_io_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Blank wins over the digit value so a hidden digit is fully dark.
    always_comb begin
        o_seg = i_blank ? SEG_OFF : seg_pattern(i_nibble);
    end

endmodule

// File: rtl/dnn_io_ctrl.sv
// Board I/O controller: debounced switches with edge interrupts, LED and
// seven-segment display registers behind a fixed-latency Avalon-MM slave.
module dnn_io_ctrl
    import dnn_io_pkg::*;
#(
    parameter int SW_W    = 8,
    parameter int LED_W   = 8,
    parameter int NUM_HEX = 1,
    parameter int DB_CYC  = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    dnn_io_ctrl_if.slave         bus,
    input  logic [SW_W-1:0]      switches,
    output logic [LED_W-1:0]     leds,
    output logic [7*NUM_HEX-1:0] hex
);

    localparam int PRE_W = $clog2(DB_CYC);
    localparam int HV_W  = 4 * NUM_HEX;

    logic [SW_W-1:0]      r_sw_meta;
    logic [SW_W-1:0]      r_sw_sync;
    logic [SW_W-1:0]      r_sample;
    logic [SW_W-1:0]      r_db;
    logic [SW_W-1:0]      r_edge;
    logic [SW_W-1:0]      r_irqmask;
    logic [LED_W-1:0]     r_led;
    logic [HV_W-1:0]      r_hexval;
    logic [NUM_HEX-1:0]   r_hexblank;
    logic [PRE_W-1:0]     r_pre;
    logic [31:0]          r_rdata;
    logic                 r_irq;
    logic [7*NUM_HEX-1:0] r_hex;

    logic                 w_tick;
    logic [SW_W-1:0]      w_db_next;
    logic [SW_W-1:0]      w_edge_set;
    logic [SW_W-1:0]      w_edge_clr;
    logic                 w_wr_led;
    logic                 w_wr_hexval;
    logic                 w_wr_hexblank;
    logic                 w_wr_edge;
    logic                 w_wr_irqmask;
    logic [31:0]          w_rdata;
    logic [7*NUM_HEX-1:0] w_seg;
    logic                 w_unused_wdata;

    assign w_tick = (r_pre == PRE_W'(DB_CYC - 1));

    assign w_wr_led      = bus.avs_write && (bus.avs_address == REG_LED);
    assign w_wr_hexval   = bus.avs_write && (bus.avs_address == REG_HEXVAL);
    assign w_wr_hexblank = bus.avs_write && (bus.avs_address == REG_HEXBLANK);
    assign w_wr_edge     = bus.avs_write && (bus.avs_address == REG_EDGE);
    assign w_wr_irqmask  = bus.avs_write && (bus.avs_address == REG_IRQMASK);

    // Write data above the register widths is intentionally discarded.
    assign w_unused_wdata = ^bus.avs_writedata;

    // A bit follows the synchronised input only when two consecutive tick
    // samples agree. Reset zeroes both the sample and the debounced state,
    // so the first tick after release can never register a change.
    for (genvar gi = 0; gi < SW_W; gi++) begin : g_db
        assign w_db_next[gi] = (w_tick && (r_sw_sync[gi] == r_sample[gi]))
                             ? r_sw_sync[gi] : r_db[gi];
    end

    assign w_edge_set = w_db_next ^ r_db;
    assign w_edge_clr = w_wr_edge ? bus.avs_writedata[SW_W-1:0] : '0;

    // Read mux from the current (pre-write) register contents.
    always_comb begin
        w_rdata = '0;
        case (bus.avs_address)
            REG_SW:       w_rdata[SW_W-1:0]    = r_db;
            REG_LED:      w_rdata[LED_W-1:0]   = r_led;
            REG_HEXVAL:   w_rdata[HV_W-1:0]    = r_hexval;
            REG_HEXBLANK: w_rdata[NUM_HEX-1:0] = r_hexblank;
            REG_EDGE:     w_rdata[SW_W-1:0]    = r_edge;
            REG_IRQMASK:  w_rdata[SW_W-1:0]    = r_irqmask;
            default:      ;
        endcase
    end

    for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_hex
        seg7_decode u_seg7_decode (
            .i_nibble (r_hexval[4*gi +: 4]),
            .i_blank  (r_hexblank[gi]),
            .o_seg    (w_seg[7*gi +: 7])
        );
    end

    // Synchroniser, free-running prescaler and debounce sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_pre     <= '0;
            r_sample  <= '0;
            r_db      <= '0;
        end else begin
            r_sw_meta <= switches;
            r_sw_sync <= r_sw_meta;
            r_pre     <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_sample <= r_sw_sync;
            end
            r_db <= w_db_next;
        end
    end

    // Host-visible registers; a new edge overrides a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led      <= '0;
            r_hexval   <= '0;
            r_hexblank <= '1;
            r_edge     <= '0;
            r_irqmask  <= '0;
        end else begin
            if (w_wr_led)      r_led      <= bus.avs_writedata[LED_W-1:0];
            if (w_wr_hexval)   r_hexval   <= bus.avs_writedata[HV_W-1:0];
            if (w_wr_hexblank) r_hexblank <= bus.avs_writedata[NUM_HEX-1:0];
            if (w_wr_irqmask)  r_irqmask  <= bus.avs_writedata[SW_W-1:0];
            r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
        end
    end

    // Registered outputs: read data, interrupt and segment drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
            r_hex   <= '1;
        end else begin
            if (bus.avs_read) begin
                r_rdata <= w_rdata;
            end
            r_irq <= |(r_edge & r_irqmask);
            r_hex <= w_seg;
        end
    end

    assign bus.avs_readdata = r_rdata;
    assign bus.irq          = r_irq;
    assign leds             = r_led;
    assign hex              = r_hex;

endmodule

// File: tb/tb_dnn_io_ctrl.sv
// Bench for dnn_io_ctrl: directed register table, hand-written debounce,
// interrupt and reset sequences, then random traffic against a model.
module tb_dnn_io_ctrl;

    localparam int SW_W    = 8;
    localparam int LED_W   = 8;
    localparam int NUM_HEX = 2;
    localparam int DB_CYC  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  switches = '0;
    logic [7:0]  leds;
    logic [13:0] hex;

    dnn_io_ctrl_if u_if ();

    dnn_io_ctrl #(
        .SW_W    (SW_W),
        .LED_W   (LED_W),
        .NUM_HEX (NUM_HEX),
        .DB_CYC  (DB_CYC)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (u_if),
        .switches (switches),
        .leds     (leds),
        .hex      (hex)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [7:0]  m_led = '0, m_hexval = '0, m_edge = '0, m_mask = '0;
    logic [7:0]  m_db = '0, m_prev = '0;
    logic [1:0]  m_blank = 2'b11;
    logic [7:0]  m_swq [2] = '{8'h00, 8'h00};
    int          m_pcnt = 0;
    logic [31:0] m_rd = '0;
    logic        m_rd_valid = 1'b0;
    logic        m_irq = 1'b0;
    logic [13:0] m_hex = 14'h3FFF;

    function automatic logic [13:0] ref_hex(input logic [7:0] hv, input logic [1:0] bl);
        logic [13:0] r;
        for (int d = 0; d < 2; d++)
            r[7*d +: 7] = bl[d] ? 7'h7F : seg_ref[hv[4*d +: 4]];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'b0, m_db};
            3'd1: return {24'b0, m_led};
            3'd2: return {24'b0, m_hexval};
            3'd3: return {30'b0, m_blank};
            3'd4: return {24'b0, m_edge};
            3'd5: return {24'b0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [7:0] s, chg, clr;
        logic       tick;
        if (reset) begin
            m_led = '0; m_hexval = '0; m_blank = 2'b11; m_edge = '0; m_mask = '0;
            m_db = '0; m_prev = '0; m_pcnt = 0; m_swq[0] = '0; m_swq[1] = '0;
            m_rd = '0; m_rd_valid = 1'b1; m_irq = 1'b0; m_hex = 14'h3FFF;
        end else begin
            s = m_swq[1];
            m_rd_valid = u_if.avs_read;
            if (u_if.avs_read) m_rd = ref_read(u_if.avs_address);
            m_irq = |(m_edge & m_mask);
            m_hex = ref_hex(m_hexval, m_blank);
            tick = (m_pcnt == DB_CYC - 1);
            m_pcnt = tick ? 0 : m_pcnt + 1;
            chg = '0;
            if (tick) begin
                for (int i = 0; i < SW_W; i++)
                    if (s[i] == m_prev[i] && s[i] != m_db[i]) chg[i] = 1'b1;
                m_db   = m_db ^ chg;
                m_prev = s;
            end
            clr = '0;
            if (u_if.avs_write) begin
                case (u_if.avs_address)
                    3'd1: m_led    = u_if.avs_writedata[7:0];
                    3'd2: m_hexval = u_if.avs_writedata[7:0];
                    3'd3: m_blank  = u_if.avs_writedata[1:0];
                    3'd4: clr      = u_if.avs_writedata[7:0];
                    3'd5: m_mask   = u_if.avs_writedata[7:0];
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~clr) | chg;
            m_swq[1] = m_swq[0];
            m_swq[0] = switches;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Every cycle the visible outputs must track the model.
    initial forever begin
        @(negedge clk);
        chk("cyc_leds", {24'b0, leds}, {24'b0, m_led});
        chk("cyc_hex", {18'b0, hex}, {18'b0, m_hex});
        chk("cyc_irq", {31'b0, u_if.irq}, {31'b0, m_irq});
        if (m_rd_valid) chk("cyc_rdata", u_if.avs_readdata, m_rd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        u_if.avs_address = a; u_if.avs_writedata = d; u_if.avs_write = 1'b1;
        step();
        u_if.avs_write = 1'b0;
        $display("wr addr=%0d data=%h", a, d);
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        u_if.avs_address = a; u_if.avs_read = 1'b1;
        step();
        u_if.avs_read = 1'b0;
        $display("rd addr=%0d data=%h", a, u_if.avs_readdata);
        chk(nm, u_if.avs_readdata, exp);
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        bit found;
        u_if.avs_address = '0; u_if.avs_read = 1'b0;
        u_if.avs_write = 1'b0; u_if.avs_writedata = '0;

        vecs[0] = '{3'd1, 1'b1, 32'h0000_00A5, 32'h0000_00A5};  // LED
        vecs[1] = '{3'd1, 1'b1, 32'hFFFF_FF3C, 32'h0000_003C};  // LED truncation
        vecs[2] = '{3'd2, 1'b1, 32'h0000_013C, 32'h0000_003C};  // HEXVAL truncation
        vecs[3] = '{3'd3, 1'b1, 32'hFFFF_FFFE, 32'h0000_0002};  // HEXBLANK truncation
        vecs[4] = '{3'd5, 1'b1, 32'h0000_0100, 32'h0000_0000};  // IRQMASK truncation
        vecs[5] = '{3'd0, 1'b1, 32'h0000_00FF, 32'h0000_0000};  // SW is read-only
        vecs[6] = '{3'd6, 1'b1, 32'h1234_5678, 32'h0000_0000};  // unmapped
        vecs[7] = '{3'd7, 1'b0, 32'h0000_0000, 32'h0000_0000};  // unmapped
        vecs[8] = '{3'd4, 1'b1, 32'h0000_00FF, 32'h0000_0000};  // W1C on empty EDGE

        repeat (3) step();
        reset = 1'b0;

        // Reset state
        chk("rst_hex", {18'b0, hex}, 32'h0000_3FFF);
        chk("rst_irq", {31'b0, u_if.irq}, 32'h0);
        for (int a = 0; a < 8; a++)
            bus_rd(3'(a), (a == 3) ? 32'h3 : 32'h0, "rst_read");

        // LED and display path timing
        bus_wr(3'd1, 32'hA5);
        chk("led_next", {24'b0, leds}, 32'hA5);
        bus_wr(3'd2, 32'h3C);
        bus_wr(3'd3, 32'h0);
        chk("hex_before", {18'b0, hex}, 32'h3FFF);
        step();
        chk("hex_after", {18'b0, hex}, {18'b0, 7'h30, 7'h46});

        // Register table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].wdata);
            bus_rd(vecs[i].addr, vecs[i].exp, "table");
        end

        // Short glitch is rejected
        switches[0] = 1'b1;
        repeat (3) step();
        switches[0] = 1'b0;
        repeat (20) step();
        bus_rd(3'd0, 32'h0, "glitch_sw");
        bus_rd(3'd4, 32'h0, "glitch_edge");
        // Stable level is accepted
        switches[0] = 1'b1;
        repeat (12) step();
        bus_rd(3'd0, 32'h1, "stable_sw");
        bus_rd(3'd4, 32'h1, "stable_edge");

        // Interrupt on masked edge, cleared by W1C
        bus_wr(3'd4, 32'h1);
        bus_wr(3'd5, 32'h1);
        switches[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (u_if.irq) found = 1'b1;
        end
        chk("irq_rise", {31'b0, found}, 32'h1);
        bus_wr(3'd4, 32'h1);
        chk("irq_hold", {31'b0, u_if.irq}, 32'h1);
        step();
        chk("irq_clear", {31'b0, u_if.irq}, 32'h0);

        // Clear coinciding with a new edge: the set survives
        switches[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (m_pcnt == DB_CYC - 1 && m_swq[1][0] == m_prev[0] && m_swq[1][0] != m_db[0]) begin
                bus_wr(3'd4, 32'h1);
                found = 1'b1;
            end
        end
        chk("coinc_found", {31'b0, found}, 32'h1);
        bus_rd(3'd4, 32'h1, "coinc_edge");

        // Reset mid-operation overrides a coincident write
        bus_wr(3'd1, 32'hFF);
        switches = '0;
        reset = 1'b1;
        u_if.avs_address = 3'd1; u_if.avs_writedata = 32'h12; u_if.avs_write = 1'b1;
        step();
        reset = 1'b0; u_if.avs_write = 1'b0;
        chk("mid_rst_leds", {24'b0, leds}, 32'h0);
        chk("mid_rst_hex", {18'b0, hex}, 32'h3FFF);
        chk("mid_rst_irq", {31'b0, u_if.irq}, 32'h0);
        chk("mid_rst_rdata", u_if.avs_readdata, 32'h0);
        bus_rd(3'd4, 32'h0, "mid_rst_edge");
        bus_rd(3'd1, 32'h0, "mid_rst_led");
        bus_rd(3'd3, 32'h3, "mid_rst_blank");
        bus_rd(3'd5, 32'h0, "mid_rst_mask");

        // Random traffic; the per-cycle checker compares against the model
        for (int c = 0; c < 600; c++) begin
            int op;
            if ($urandom_range(0, 24) == 0) switches[$urandom_range(0, 7)] ^= 1'b1;
            reset = ($urandom_range(0, 299) == 0);
            op = $urandom_range(0, 9);
            u_if.avs_address   = 3'($urandom_range(0, 7));
            u_if.avs_writedata = $urandom;
            u_if.avs_read      = (op < 3) || (op == 5);
            u_if.avs_write     = (op == 3) || (op == 4) || (op == 5);
            if (u_if.avs_read || u_if.avs_write)
                $display("rnd rd=%0d wr=%0d addr=%0d data=%h rst=%0d", u_if.avs_read,
                         u_if.avs_write, u_if.avs_address, u_if.avs_writedata, reset);
            step();
        end
        reset = 1'b0; u_if.avs_read = 1'b0; u_if.avs_write = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
